cv32e40p_x_result_buf: RTL
==========================

Name: cv32e40p_x_result_buf

Overview:
- Sits directly downstream of the X-interface dispatcher, on the coprocessor result channel.
- Accepts results from the coprocessor and writes them into register-file write port B, which is shared with core writeback.
- Buffers results in a small FIFO while the core owns the port.
- Produces the scoreboard-clear strobe the dispatcher consumes, plus pending-register hit flags for operand hazard checks.

Parameters:
- DEPTH, 2, number of FIFO entries (power of two, >=2).
- STARVE_LIMIT, 4, consecutive blocked cycles of a valid head before the core is stalled.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- x_result_valid_i  in  1  coprocessor result valid.
- x_result_ready_o  out  1  result accepted when high together with valid.
- x_result_id_i  in  4  instruction id.
- x_result_data_i  in  32  result data.
- x_result_rd_i  in  5  destination register.
- x_result_we_i  in  1  result writes a register.
- core_we_wb_i  in  1  core writeback owns port B this cycle.
- rf_we_o  out  1  port B write enable (X side).
- rf_waddr_o  out  5  port B address.
- rf_wdata_o  out  32  port B data.
- sb_clr_valid_o  out  1  scoreboard clear strobe to dispatcher.
- sb_clr_rd_o  out  5  register to clear.
- retired_id_o  out  4  id of result retired this cycle.
- retired_valid_o  out  1  a result retired this cycle (written or dropped).
- x_rs_addr_i  in  3x5  operand addresses of the instruction in ID.
- pending_hit_o  out  3  operand i matches a buffered rd with we=1.
- x_starve_stall_o  out  1  request to hold core writeback.
- level_o  out  clog2(DEPTH+1)  occupancy.

Behaviour:
- Reset: FIFO empty, level_o=0, starvation counter=0. All outputs 0 except x_result_ready_o=1.
- x_result_ready_o = (level < DEPTH). It is combinational from level only; a pop in the same cycle never re-opens a full FIFO.
- Accept occurs on valid & ready. A result with we=0 or rd=0 is "drop-type": it is never written to the register file.
- Write slot exists when core_we_wb_i=0.
- Retire rule, in priority order:
  1. FIFO non-empty and write slot: pop head.
  2. FIFO empty, accept, and write slot: bypass; the incoming result retires in the same cycle with zero latency and is not stored.
  3. Otherwise an accepted result is pushed.
  4. With FIFO non-empty, an accept and a pop in the same cycle: push and pop both occur, level unchanged, order preserved.
- Drop-type results retire without needing a write slot:
  - At the head, they pop even when core_we_wb_i=1.
  - When arriving into an empty FIFO, they bypass regardless of core_we_wb_i.
- On retire of a write-type result:
  - rf_we_o=1, rf_waddr_o=rd, rf_wdata_o=data, sb_clr_valid_o=1, sb_clr_rd_o=rd.
  - retired_valid_o=1, retired_id_o=id.
- On retire of a drop-type result: retired_valid_o=1 with its id; rf_we_o=0 and sb_clr_valid_o=0.
- When no write-type retire occurs, rf_waddr_o, rf_wdata_o and sb_clr_rd_o are 0.
- Strict in-order retirement; at most one retire per cycle.
- pending_hit_o[i]=1 iff some valid entry has we=1, rd!=0, rd==x_rs_addr_i[i]. The entry being popped this cycle still counts.
- Starvation counter:
  - Increments each cycle the head is write-type and core_we_wb_i=1.
  - Saturates at STARVE_LIMIT.
  - Clears on any pop or when the FIFO is empty.
  - x_starve_stall_o = (counter == STARVE_LIMIT). It is registered, so it asserts the cycle after the limit is reached.
  - The core must then deassert core_we_wb_i. The head drains that cycle and the stall drops the following cycle.
- Pointers wrap modulo DEPTH; level is a separate counter (DEPTH+1 states).
- Asynchronous reset mid-operation discards all buffered results. The dispatcher scoreboard is reset concurrently.

Test Plan:
1. Empty FIFO, core_we_wb_i=0, result rd=5 data=0xDEADBEEF id=3 -> same cycle: rf_we_o=1, rf_waddr_o=5, sb_clr_rd_o=5, retired_id_o=3, level_o stays 0.
2. core_we_wb_i=1 held; results rd=1,2 -> level_o=2, ready drops; third result stalls; pending_hit_o=3'b011 for rs={2,1,x}. Release -> writes rd=1 then rd=2 on consecutive cycles; ready high again the cycle level_o becomes 1.
3. Drop-type result (we=0, id=7) at head with core_we_wb_i=1 -> pops immediately; retired_valid_o=1, retired_id_o=7, rf_we_o=0, sb_clr_valid_o=0.
4. STARVE_LIMIT=4, head write-type, core_we_wb_i=1 for 4 cycles -> x_starve_stall_o=1 on cycle 5. Drop core_we_wb_i -> head written; stall 0 next cycle.
5. FIFO with 1 entry: simultaneous accept and pop -> level_o stays 1; write order matches arrival order. rd=0 write-type result -> no rf write.
6. Assert rst_ni low with 2 entries buffered -> level_o=0, ready=1, no rf write after release.

Source files
------------

// File: rtl/cv32e40p_x_result_buf.sv
// cv32e40p_x_result_buf: buffers coprocessor results and retires them in order onto
// register-file write port B whenever core writeback leaves the port free.
module cv32e40p_x_result_buf #(
  parameter int DEPTH = 2,
  parameter int STARVE_LIMIT = 4,
  localparam int LW = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          x_result_valid_i,
  output logic          x_result_ready_o,
  input  logic [3:0]    x_result_id_i,
  input  logic [31:0]   x_result_data_i,
  input  logic [4:0]    x_result_rd_i,
  input  logic          x_result_we_i,
  input  logic          core_we_wb_i,
  output logic          rf_we_o,
  output logic [4:0]    rf_waddr_o,
  output logic [31:0]   rf_wdata_o,
  output logic          sb_clr_valid_o,
  output logic [4:0]    sb_clr_rd_o,
  output logic [3:0]    retired_id_o,
  output logic          retired_valid_o,
  input  logic [14:0]   x_rs_addr_i,
  output logic [2:0]    pending_hit_o,
  output logic          x_starve_stall_o,
  output logic [LW-1:0] level_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  logic [31:0] data_q [DEPTH];
  logic [4:0] rd_q [DEPTH];
  logic [3:0] id_q [DEPTH];
  logic [DEPTH-1:0] wr_q, vld_q;
  logic [PW-1:0] rptr, wptr;
  logic [CW-1:0] cnt;
  logic empty, accept, in_wr, head_wr, pop, bypass, push, ret_wr;
  logic [4:0] ret_rd;
  logic [31:0] ret_data;
  logic [3:0] ret_id;
  assign empty = level_o == '0;
  assign x_result_ready_o = level_o < LW'(DEPTH);
  assign accept = x_result_valid_i && x_result_ready_o;
  // wr_q holds "write-type": we=1 and rd!=0; everything else retires without a slot
  assign in_wr = x_result_we_i && x_result_rd_i != 5'd0;
  assign head_wr = wr_q[rptr];
  assign pop = !empty && (!core_we_wb_i || !head_wr);
  assign bypass = empty && accept && (!core_we_wb_i || !in_wr);
  assign push = accept && !bypass;
  assign ret_wr = pop ? head_wr : bypass && in_wr;
  assign ret_rd = pop ? rd_q[rptr] : x_result_rd_i;
  assign ret_data = pop ? data_q[rptr] : x_result_data_i;
  assign ret_id = pop ? id_q[rptr] : x_result_id_i;
  assign rf_we_o = ret_wr;
  assign rf_waddr_o = ret_wr ? ret_rd : '0;
  assign rf_wdata_o = ret_wr ? ret_data : '0;
  assign sb_clr_valid_o = ret_wr;
  assign sb_clr_rd_o = ret_wr ? ret_rd : '0;
  assign retired_valid_o = pop || bypass;
  assign retired_id_o = retired_valid_o ? ret_id : '0;
  assign x_starve_stall_o = cnt == CW'(STARVE_LIMIT);
  always_comb begin
    pending_hit_o = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < DEPTH; j++)
        if (vld_q[j] && wr_q[j] && rd_q[j] == x_rs_addr_i[5*i +: 5]) pending_hit_o[i] = 1'b1;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rptr <= '0;
      wptr <= '0;
      level_o <= '0;
      vld_q <= '0;
      wr_q <= '0;
      cnt <= '0;
    end else begin
      if (push) begin
        wptr <= wptr + PW'(1);
        vld_q[wptr] <= 1'b1;
        wr_q[wptr] <= in_wr;
      end
      if (pop) begin
        rptr <= rptr + PW'(1);
        vld_q[rptr] <= 1'b0;
      end
      level_o <= level_o + LW'(push) - LW'(pop);
      cnt <= (empty || pop) ? '0 :
             (head_wr && core_we_wb_i && !x_starve_stall_o) ? cnt + CW'(1) : cnt;
    end
  end
  always_ff @(posedge clk_i) begin
    if (push) begin
      data_q[wptr] <= x_result_data_i;
      rd_q[wptr] <= x_result_rd_i;
      id_q[wptr] <= x_result_id_i;
    end
  end
endmodule
